// File: rtl/uart_rx_async_pkg.sv
// Shared definitions for the asynchronous UART receiver: state encoding and
// oversampling tick positions.
package uart_rx_async_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Oversample tick at the middle of the start bit and at one full bit later.
  localparam logic [3:0] SAMP_MID = 4'd7;
  localparam logic [3:0] SAMP_END = 4'd15;

  // Index of the final data bit for the selected word length.
  function automatic logic [2:0] last_bit_idx(input logic bit8);
    return bit8 ? 3'd7 : 3'd6;
  endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Input conditioning for the serial line: a 2-flop synchroniser followed by a
// 3-sample majority filter clocked by the 16x baud enable.
module uart_rx_filter (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_baud_clock,
  input  logic i_rx,
  output logic o_rx_f
);

  logic [1:0] r_sync;
  logic [2:0] r_samp;

  // Bring the asynchronous pin into the clk domain; idle level is high.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rx};
    end
  end

  // Keep the last three synchronised samples taken on baud ticks.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_samp <= 3'b111;
    end else if (i_baud_clock) begin
      r_samp <= {r_samp[1:0], r_sync[1]};
    end
  end

  // Majority of three rejects single-sample spikes.
  assign o_rx_f = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

endmodule

// File: rtl/uart_rx_async.sv
// Asynchronous UART receiver: 16x oversampled, 7/8 data bits LSB first,
// optional parity, one stop bit; delivers bytes to a holding register or an
// external RX FIFO and keeps sticky error flags.
module uart_rx_async
  import uart_rx_async_pkg::*;
#(
  parameter int unsigned RX_FIFO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       clear_parity,
  input  logic       clear_framing,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  output logic [7:0] rx_byte,
  output logic       rxrdy,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       fifo_write_n,
  output logic       rx_idle
);

  logic       w_rx_f;
  logic       w_complete;

  rx_state_e  r_state;
  logic [3:0] r_samp_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_acc;
  logic       r_perr;
  logic       r_armed;

  logic [7:0] r_rx_byte;
  logic       r_rxrdy;
  logic       r_parity_err;
  logic       r_framing_err;
  logic       r_overflow;
  logic       r_fifo_write_n;

  uart_rx_filter u_filter (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_baud_clock (baud_clock),
    .i_rx         (rx),
    .o_rx_f       (w_rx_f)
  );

  // Receive FSM with sample/bit counters, shift register and parity check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RX_IDLE;
      r_samp_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_acc      <= 1'b0;
      r_perr     <= 1'b0;
      r_armed    <= 1'b0;
    end else if (baud_clock) begin
      unique case (r_state)
        RX_IDLE: begin
          if (r_armed && !w_rx_f) begin
            r_state    <= RX_START;
            r_samp_cnt <= 4'd0;
          end else if (w_rx_f) begin
            r_armed <= 1'b1;
          end
        end
        RX_START: begin
          if (r_samp_cnt == SAMP_MID) begin
            if (!w_rx_f) begin
              r_state    <= RX_DATA;
              r_samp_cnt <= 4'd0;
              r_bit_cnt  <= 3'd0;
              r_shift    <= 8'd0;
              r_acc      <= 1'b0;
              r_perr     <= 1'b0;
            end else begin
              r_state <= RX_IDLE;
            end
          end else begin
            r_samp_cnt <= r_samp_cnt + 4'd1;
          end
        end
        RX_DATA: begin
          r_samp_cnt <= r_samp_cnt + 4'd1;
          if (r_samp_cnt == SAMP_END) begin
            r_shift[r_bit_cnt] <= w_rx_f;
            r_acc              <= r_acc ^ w_rx_f;
            // bit_cnt saturating at 7 guarantees exit even if bit8 changes mid-frame.
            if (r_bit_cnt == last_bit_idx(bit8) || r_bit_cnt == 3'd7) begin
              r_state <= parity_en ? RX_PARITY : RX_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        RX_PARITY: begin
          r_samp_cnt <= r_samp_cnt + 4'd1;
          if (r_samp_cnt == SAMP_END) begin
            r_perr  <= ((r_acc ^ w_rx_f) != odd_n_even);
            r_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          r_samp_cnt <= r_samp_cnt + 4'd1;
          if (r_samp_cnt == SAMP_END) begin
            r_state <= RX_IDLE;
            // A low stop bit (break) blocks a new start until the line idles high.
            r_armed <= w_rx_f;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign w_complete = baud_clock && (r_state == RX_STOP) && (r_samp_cnt == SAMP_END);

  // Byte delivery and sticky flags; sets are written last so they beat clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_byte      <= 8'd0;
      r_rxrdy        <= 1'b0;
      r_parity_err   <= 1'b0;
      r_framing_err  <= 1'b0;
      r_overflow     <= 1'b0;
      r_fifo_write_n <= 1'b1;
    end else begin
      r_fifo_write_n <= 1'b1;
      if (read_rx_byte) begin
        if (RX_FIFO == 0) r_rxrdy <= 1'b0;
        r_overflow <= 1'b0;
      end
      if (clear_parity)  r_parity_err  <= 1'b0;
      if (clear_framing) r_framing_err <= 1'b0;
      if (RX_FIFO != 0)  r_rxrdy <= !fifo_empty;
      if (w_complete) begin
        if (!w_rx_f) r_framing_err <= 1'b1;
        if (r_perr)  r_parity_err  <= 1'b1;
        if (RX_FIFO == 0) begin
          if (!r_rxrdy) begin
            r_rx_byte <= r_shift;
            r_rxrdy   <= 1'b1;
          end else begin
            r_overflow <= 1'b1;
          end
        end else begin
          if (!fifo_full) begin
            r_rx_byte      <= r_shift;
            r_fifo_write_n <= 1'b0;
          end else begin
            r_overflow <= 1'b1;
          end
        end
      end
    end
  end

  assign rx_byte      = r_rx_byte;
  assign rxrdy        = r_rxrdy;
  assign parity_err   = r_parity_err;
  assign framing_err  = r_framing_err;
  assign overflow     = r_overflow;
  assign fifo_write_n = r_fifo_write_n;
  assign rx_idle      = (r_state == RX_IDLE);

endmodule

// File: tb/tb_uart_rx_async.sv
// Bench for uart_rx_async: one instance per delivery mode sharing the serial
// line, checked against a frame-level model of the expected outcome.
module tb_uart_rx_async;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, baud_clock, rx, bit8, parity_en, odd_n_even;
  logic read_rx_byte, clear_parity, clear_framing, fifo_full, fifo_empty;

  logic [7:0] rx_byte0, rx_byte1;
  logic rxrdy0, perr0, ferr0, ovf0, fwn0, idle0;
  logic rxrdy1, perr1, ferr1, ovf1, fwn1, idle1;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_async #(.RX_FIFO(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .clear_parity(clear_parity), .clear_framing(clear_framing), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .rx_byte(rx_byte0), .rxrdy(rxrdy0), .parity_err(perr0),
    .framing_err(ferr0), .overflow(ovf0), .fifo_write_n(fwn0), .rx_idle(idle0)
  );

  uart_rx_async #(.RX_FIFO(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .clear_parity(clear_parity), .clear_framing(clear_framing), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .rx_byte(rx_byte1), .rxrdy(rxrdy1), .parity_err(perr1),
    .framing_err(ferr1), .overflow(ovf1), .fifo_write_n(fwn1), .rx_idle(idle1)
  );

  // 16x baud enable: one clk in every four.
  int bcnt = 0;
  initial baud_clock = 1'b0;
  always @(negedge clk) begin
    bcnt = (bcnt == 3) ? 0 : bcnt + 1;
    baud_clock = (bcnt == 0);
  end

  // Observers for write strobes and FSM activity.
  int   wr_pulses = 0;
  int   wr_low = 0;
  logic prev_fwn = 1'b1;
  logic left_idle0 = 1'b0;
  always @(negedge clk) begin
    if (!fwn1) wr_low++;
    if (prev_fwn && !fwn1) wr_pulses++;
    prev_fwn = fwn1;
    if (!idle0) left_idle0 = 1'b1;
  end

  // Expected state.
  logic [7:0] m_byte0, m_byte1;
  logic m_rxrdy0, m_ovf0, m_ovf1, m_perr, m_ferr;
  int   m_writes = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_byte0 = 8'd0; m_byte1 = 8'd0; m_rxrdy0 = 1'b0;
    m_ovf0 = 1'b0; m_ovf1 = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic check_reset(input string t);
    #1;
    chk({t, ".byte0"}, rx_byte0, 0); chk({t, ".byte1"}, rx_byte1, 0);
    chk({t, ".rdy0"}, rxrdy0, 0);    chk({t, ".rdy1"}, rxrdy1, 0);
    chk({t, ".flags0"}, {perr0, ferr0, ovf0}, 0);
    chk({t, ".flags1"}, {perr1, ferr1, ovf1}, 0);
    chk({t, ".fwn"}, {fwn0, fwn1}, 2'b11);
    chk({t, ".idle"}, {idle0, idle1}, 2'b11);
  endtask

  task automatic check_all(input string t);
    #1;
    chk({t, ".byte0"}, rx_byte0, m_byte0);
    chk({t, ".rdy0"}, rxrdy0, m_rxrdy0);
    chk({t, ".ovf0"}, ovf0, m_ovf0);
    chk({t, ".perr"}, {perr0, perr1}, {m_perr, m_perr});
    chk({t, ".ferr"}, {ferr0, ferr1}, {m_ferr, m_ferr});
    chk({t, ".byte1"}, rx_byte1, m_byte1);
    chk({t, ".rdy1"}, rxrdy1, !fifo_empty);
    chk({t, ".ovf1"}, ovf1, m_ovf1);
    chk({t, ".wr_pulses"}, wr_pulses, m_writes);
    chk({t, ".wr_low"}, wr_low, m_writes);
    chk({t, ".idle"}, {idle0, idle1}, 2'b11);
  endtask

  task automatic pulse(input int which);
    case (which)
      0: begin read_rx_byte = 1'b1; m_rxrdy0 = 1'b0; m_ovf0 = 1'b0; m_ovf1 = 1'b0; end
      1: begin clear_parity = 1'b1; m_perr = 1'b0; end
      default: begin clear_framing = 1'b1; m_ferr = 1'b0; end
    endcase
    wait_clks(1);
    read_rx_byte = 1'b0; clear_parity = 1'b0; clear_framing = 1'b0;
    wait_clks(2);
  endtask

  // Drive one frame after an idle gap, then update the model from the frame rules.
  task automatic send_frame(input string t, input logic [7:0] d, input logic b8,
                            input logic pen, input logic odd, input logic bad,
                            input logic stop, input int gap);
    logic [7:0] dm;
    bit8 = b8; parity_en = pen; odd_n_even = odd;
    dm = b8 ? d : {1'b0, d[6:0]};
    rx = 1'b1; wait_clks(gap);
    rx = 1'b0; wait_clks(64);
    for (int i = 0; i < (b8 ? 8 : 7); i++) begin
      rx = dm[i]; wait_clks(64);
    end
    if (pen) begin
      rx = (^dm) ^ odd ^ bad; wait_clks(64);
    end
    rx = stop; wait_clks(64);
    if (pen && bad) m_perr = 1'b1;
    if (!stop) m_ferr = 1'b1;
    if (!m_rxrdy0) begin m_byte0 = dm; m_rxrdy0 = 1'b1; end
    else m_ovf0 = 1'b1;
    if (!fifo_full) begin m_byte1 = dm; m_writes++; end
    else m_ovf1 = 1'b1;
    check_all(t);
  endtask

  initial begin
    reset_n = 1'b0; rx = 1'b1; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    read_rx_byte = 1'b0; clear_parity = 1'b0; clear_framing = 1'b0;
    fifo_full = 1'b0; fifo_empty = 1'b1;
    model_reset();
    wait_clks(10);
    check_reset("rst");
    reset_n = 1'b1;
    wait_clks(64);

    // T1: 8N1 0xA5, then host read.
    send_frame("t1", 8'hA5, 1, 0, 0, 0, 1, 64);
    pulse(0);
    check_all("t1rd");

    // T2: 7E1 0x35 with good then bad parity, then clear.
    send_frame("t2a", 8'h35, 0, 1, 0, 0, 1, 64);
    pulse(0);
    send_frame("t2b", 8'h35, 0, 1, 0, 1, 1, 64);
    pulse(1);
    check_all("t2clr");

    // T3: back-to-back frames without a read.
    pulse(0);
    send_frame("t3a", 8'h11, 1, 0, 0, 0, 1, 64);
    send_frame("t3b", 8'h22, 1, 0, 0, 0, 1, 0);

    // T4: framing error followed by a long break.
    pulse(0);
    send_frame("t4", 8'h5A, 1, 0, 0, 0, 0, 64);
    rx = 1'b0; wait_clks(3 * 10 * 64);
    rx = 1'b1; wait_clks(128);
    check_all("t4brk");
    pulse(0); pulse(2);

    // T5: 5-sample glitch is a false start; 2-clk glitch never leaves idle.
    wait_clks(64);
    left_idle0 = 1'b0;
    rx = 1'b0; wait_clks(20); rx = 1'b1; wait_clks(128);
    chk("t5.false_start", left_idle0, 1'b1);
    check_all("t5a");
    left_idle0 = 1'b0;
    rx = 1'b0; wait_clks(2); rx = 1'b1; wait_clks(128);
    chk("t5.short", left_idle0, 1'b0);
    check_all("t5b");

    // T6: FIFO write, FIFO full, then reset during data bits.
    fifo_full = 1'b0;
    send_frame("t6a", 8'hC3, 1, 0, 0, 0, 1, 64);
    fifo_full = 1'b1;
    send_frame("t6b", 8'hC3, 1, 0, 0, 0, 1, 64);
    fifo_full = 1'b0;
    rx = 1'b1; wait_clks(64);
    rx = 1'b0; wait_clks(64);
    rx = 1'b1; wait_clks(64 * 3);
    #1 chk("t6.in_data", idle0, 1'b0);
    #1 reset_n = 1'b0;
    model_reset();
    check_reset("t6rst");
    wait_clks(3);
    reset_n = 1'b1;
    rx = 1'b1;
    wait_clks(128);
    check_all("t6post");

    // Randomised frames against the model.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) pulse(0);
      if ($urandom_range(0, 2) == 0) pulse(1);
      if ($urandom_range(0, 2) == 0) pulse(2);
      fifo_full = ($urandom_range(0, 2) == 0);
      fifo_empty = 1'($urandom_range(0, 1));
      send_frame($sformatf("rnd%0d", n), d, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0),
                 64 + $urandom_range(0, 63));
    end
    rx = 1'b1;
    wait_clks(64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
